ram_sync_bytemem: RTL and testbench

- Clocked, parametrised successor to the team's asynchronous 256-byte data RAM.
- Byte-addressable, big-endian storage with byte, halfword and word access.
- Adds configurable depth and wait states, a registered MFA/MOC handshake, sign-extending loads, an error flag and address wrap-around.
- Sits between the ARM datapath's MAR/MDR and the memory bus. It is the target of the control unit's MFA/MOC wait loop.

---
 rtl/ram_sync_bytemem.sv | 182 ++++++++++++++++++
 tb/tb_ram_sync_bytemem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync_bytemem.sv
// Clocked byte-addressable big-endian data RAM with MFA/MOC handshake,
// configurable wait states, sign-extending loads and address wrap-around.
module ram_sync_bytemem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mfa,
  input  logic                  rw,
  input  logic [1:0]            mode,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  moc,
  output logic                  err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_WAIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Byte storage; intentionally not reset so contents survive rst_n.
  logic [7:0] mem [0:DEPTH-1];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [1:0]            mode_q, mode_d;
  logic                  sext_q, sext_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  moc_d, err_d;
  logic [31:0]           dout_d;

  logic [ADDR_WIDTH-1:0] addr1_c, addr2_c, addr3_c;
  logic [7:0]            b0_c, b1_c, b2_c, b3_c;
  logic                  fill_c;
  logic [31:0]           rdata_c;
  logic                  wr_c;

  // Successive byte addresses wrap naturally at the top of memory.
  assign addr1_c = addr_q + ADDR_WIDTH'(1);
  assign addr2_c = addr_q + ADDR_WIDTH'(2);
  assign addr3_c = addr_q + ADDR_WIDTH'(3);

  // Assemble the right-justified, optionally sign-extended read result.
  always_comb begin
    b0_c    = mem[addr_q];
    b1_c    = mem[addr1_c];
    b2_c    = mem[addr2_c];
    b3_c    = mem[addr3_c];
    fill_c  = 1'b0;
    rdata_c = '0;
    case (mode_q)
      MODE_BYTE: begin
        fill_c  = sext_q & b0_c[7];
        rdata_c = {{24{fill_c}}, b0_c};
      end
      MODE_HALF: begin
        fill_c  = sext_q & b0_c[7];
        rdata_c = {{16{fill_c}}, b0_c, b1_c};
      end
      MODE_WORD: rdata_c = {b0_c, b1_c, b2_c, b3_c};
      default:   rdata_c = '0;
    endcase
  end

  assign wr_c = (state_q == S_ACCESS) && !rw_q && (mode_q != MODE_RSVD);

  // Commit every byte of a store on the single ACCESS edge.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      case (mode_q)
        MODE_BYTE: mem[addr_q] <= wdata_q[7:0];
        MODE_HALF: begin
          mem[addr_q]  <= wdata_q[15:8];
          mem[addr1_c] <= wdata_q[7:0];
        end
        default: begin
          mem[addr_q]  <= wdata_q[31:24];
          mem[addr1_c] <= wdata_q[23:16];
          mem[addr2_c] <= wdata_q[15:8];
          mem[addr3_c] <= wdata_q[7:0];
        end
      endcase
    end
  end

  // Next-state and output logic; moc rises one cycle after the access lands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    mode_d  = mode_q;
    sext_d  = sext_q;
    wdata_d = wdata_q;
    moc_d   = moc;
    err_d   = err;
    dout_d  = data_out;
    case (state_q)
      S_IDLE: begin
        if (mfa) begin
          addr_d  = address;
          rw_d    = rw;
          mode_d  = mode;
          sext_d  = sign_ext;
          wdata_d = data_in;
          cnt_d   = '0;
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACCESS: begin
        if (rw_q || (mode_q == MODE_RSVD)) begin
          dout_d = rdata_c;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!moc) begin
          moc_d = 1'b1;
          err_d = (mode_q == MODE_RSVD);
        end else if (!mfa) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      mode_q   <= MODE_BYTE;
      sext_q   <= 1'b0;
      wdata_q  <= '0;
      moc      <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      mode_q   <= mode_d;
      sext_q   <= sext_d;
      wdata_q  <= wdata_d;
      moc      <= moc_d;
      err      <= err_d;
      data_out <= dout_d;
    end
  end

endmodule

// File: tb/tb_ram_sync_bytemem.sv
// Scoreboard bench for ram_sync_bytemem: driver pushes expected responses,
// monitor pops and checks them on each moc rising edge.
module tb_ram_sync_bytemem;

  localparam int unsigned AW = 8;
  localparam int unsigned WS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mfa;
  logic          rw;
  logic [1:0]    mode;
  logic          sign_ext;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [31:0]   data_out;
  logic          moc;
  logic          err;

  ram_sync_bytemem #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mfa      (mfa),
    .rw       (rw),
    .mode     (mode),
    .sign_ext (sign_ext),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .moc      (moc),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    int unsigned t_acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic        moc_prev = 1'b0;
  logic [7:0]  shadow [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string name, input logic [7:0] a, input logic [7:0] e);
    chk(name, 32'(dut.mem[a]), 32'(e));
    shadow[a] = e;
  endtask

  task automatic chk_all_mem(input string name);
    int nd = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut.mem[i] !== shadow[i]) nd++;
    end
    chk(name, 32'(nd), 32'd0);
  endtask

  // Monitor: every moc rising edge consumes one expected response.
  always @(negedge clk) begin
    if (rst_n && moc && !moc_prev) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_moc: got moc=1 data=0x%08h, want no transaction", data_out);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_data"}, data_out, mon_e.data);
        chk({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
        chk({mon_e.name, "_latency"}, cyc - mon_e.t_acc, WS + 2);
      end
    end
    moc_prev = moc;
  end

  // One request; called and returns at a falling edge. hold<0 drops mfa early.
  task automatic txn(input string name, input logic r, input logic [1:0] m,
                     input logic sx, input logic [7:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e, input int hold);
    int k = 0;
    mfa = 1'b1; rw = r; mode = m; sign_ext = sx; address = a; data_in = d;
    @(posedge clk); #1;
    sb.push_back('{name, exp_d, exp_e, cyc});
    rw = ~r; mode = ~m; sign_ext = ~sx; address = ~a; data_in = ~d;
    if (hold < 0) begin
      @(negedge clk);
      mfa = 1'b0;
    end
    while (!moc && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_moc"}, 32'(moc), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold"}, 32'(moc), 32'd1);
    end
    mfa = 1'b0;
    @(negedge clk);
    chk({name, "_moc_clr"}, 32'(moc), 32'd0);
    chk({name, "_err_clr"}, 32'(err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; mfa = 1'b0; rw = 1'b1; mode = 2'b00; sign_ext = 1'b0;
    address = '0; data_in = '0;
    for (int i = 0; i < 256; i++) begin
      dut.mem[i] = 8'(i) ^ 8'h5A;
      shadow[i]  = 8'(i) ^ 8'h5A;
    end
    dut.mem[8'h20] = 8'h80; shadow[8'h20] = 8'h80;
    dut.mem[8'h21] = 8'h01; shadow[8'h21] = 8'h01;
    dut.mem[8'h40] = 8'h01; shadow[8'h40] = 8'h01;
    dut.mem[8'h41] = 8'h02; shadow[8'h41] = 8'h02;
    dut.mem[8'h42] = 8'h03; shadow[8'h42] = 8'h03;
    dut.mem[8'h43] = 8'h04; shadow[8'h43] = 8'h04;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_moc", 32'(moc), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word write / read.
    txn("wr_word10", 1'b0, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0, 0);
    chk_mem("mem10", 8'h10, 8'hDE);
    chk_mem("mem11", 8'h11, 8'hAD);
    chk_mem("mem12", 8'h12, 8'hBE);
    chk_mem("mem13", 8'h13, 8'hEF);
    txn("rd_word10", 1'b1, 2'b10, 1'b1, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Sign extension.
    txn("rd_b20_zx", 1'b1, 2'b00, 1'b0, 8'h20, 32'h0, 32'h00000080, 1'b0, 0);
    txn("rd_b20_sx", 1'b1, 2'b00, 1'b1, 8'h20, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    txn("rd_h20_sx", 1'b1, 2'b01, 1'b1, 8'h20, 32'h0, 32'hFFFF8001, 1'b0, 0);
    txn("rd_h20_zx", 1'b1, 2'b01, 1'b0, 8'h20, 32'h0, 32'h00008001, 1'b0, 0);

    // Wrap-around at the top of memory.
    txn("wr_wordfe", 1'b0, 2'b10, 1'b0, 8'hFE, 32'h11223344, 32'h00008001, 1'b0, 0);
    chk_mem("memfe", 8'hFE, 8'h11);
    chk_mem("memff", 8'hFF, 8'h22);
    chk_mem("mem00", 8'h00, 8'h33);
    chk_mem("mem01", 8'h01, 8'h44);
    txn("rd_wordfe", 1'b1, 2'b10, 1'b0, 8'hFE, 32'h0, 32'h11223344, 1'b0, 0);
    txn("rd_hff_sx", 1'b1, 2'b01, 1'b1, 8'hFF, 32'h0, 32'h00002233, 1'b0, 0);

    // Reset while the word write sits in WAIT.
    mfa = 1'b1; rw = 1'b0; mode = 2'b10; sign_ext = 1'b0;
    address = 8'h40; data_in = 32'hCAFEF00D;
    @(posedge clk); #1;
    mfa = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_moc", 32'(moc), 32'd0);
    chk("midrst_data_out", data_out, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_mem("mem40", 8'h40, 8'h01);
    chk_mem("mem41", 8'h41, 8'h02);
    chk_mem("mem42", 8'h42, 8'h03);
    chk_mem("mem43", 8'h43, 8'h04);
    txn("rd_word40", 1'b1, 2'b10, 1'b0, 8'h40, 32'h0, 32'h01020304, 1'b0, 0);

    // Byte and halfword stores.
    txn("wr_b30", 1'b0, 2'b00, 1'b0, 8'h30, 32'h777777A5, 32'h01020304, 1'b0, 0);
    chk_mem("mem30", 8'h30, 8'hA5);
    chk_mem("mem31_pre", 8'h31, 8'h31 ^ 8'h5A);
    txn("wr_h31", 1'b0, 2'b01, 1'b0, 8'h31, 32'h1234BEEF, 32'h01020304, 1'b0, 0);
    chk_mem("mem31", 8'h31, 8'hBE);
    chk_mem("mem32", 8'h32, 8'hEF);
    chk_mem("mem33", 8'h33, 8'h69);
    txn("rd_word30", 1'b1, 2'b10, 1'b1, 8'h30, 32'h0, 32'hA5BEEF69, 1'b0, 0);

    // Handshake hold for ten cycles, then an immediate follow-on request.
    txn("rd_b13_hold", 1'b1, 2'b00, 1'b0, 8'h13, 32'h0, 32'h000000EF, 1'b0, 10);

    // Reserved mode.
    txn("rsvd_wr", 1'b0, 2'b11, 1'b0, 8'h50, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    chk_all_mem("rsvd_mem_untouched");

    // mfa dropped before DONE: moc still pulses.
    txn("rd_b20_early", 1'b1, 2'b00, 1'b1, 8'h20, 32'h0, 32'hFFFFFF80, 1'b0, -1);
    txn("rsvd_rd", 1'b1, 2'b11, 1'b0, 8'h20, 32'h0, 32'h00000000, 1'b1, 0);
    chk_all_mem("final_mem");

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, want $finish");
    $fatal(1, "watchdog");
  end

endmodule
